// File: rtl/bster_pkg.sv
// bster_pkg: shared definitions for the tree node writer.
//   Status codes, FSM state encoding, the null-pointer value, node field
//   offsets and the node-pack helper. Node layout, MSB to LSB:
//   {valid, key, data, left, right}, with both pointers RAM_ADDR_WIDTH wide.
package bster_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_RESP} state_e;
  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_FULL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  // Widest node the helper can build; callers truncate to their own width.
  localparam int NODE_MAX = 256;
  // Null pointer is all ones; callers take the low RAM_ADDR_WIDTH bits.
  localparam logic [NODE_MAX-1:0] NULL_ADDR = '1;
  function automatic int right_off(input int aw); return 0; endfunction
  function automatic int left_off(input int aw); return aw; endfunction
  function automatic int data_off(input int aw); return 2 * aw; endfunction
  function automatic int key_off(input int aw, input int dw); return 2 * aw + dw; endfunction
  function automatic int valid_off(input int aw, input int kw, input int dw);
    return 2 * aw + dw + kw;
  endfunction
  // key/data must arrive zero-extended to NODE_MAX bits.
  function automatic logic [NODE_MAX-1:0] pack_node(input logic [NODE_MAX-1:0] key,
                                                    input logic [NODE_MAX-1:0] data,
                                                    input int aw, input int kw, input int dw);
    logic [NODE_MAX-1:0] null_ptr;
    null_ptr = NULL_ADDR >> (NODE_MAX - aw);
    return (NODE_MAX'(1) << valid_off(aw, kw, dw)) | (key << key_off(aw, dw)) |
           (data << data_off(aw)) | (null_ptr << left_off(aw)) | (null_ptr << right_off(aw));
  endfunction
endpackage

// File: rtl/tree_node_writer.sv
// tree_node_writer: allocates a tree RAM slot from the space manager and writes a fresh node.
//   Ports: aclk/aresetn (async active-low); cmd_* insert command in; tree_mgt_req_* slot
//   request/grant and tree_mgt_full from the space manager; ram_* single-cycle node write;
//   done_* result (address, status) back to the tree engine; node_count saturating count
//   of successful writes. All outputs registered.
//   Optional: define TREE_WRITER_TIMEOUT_EN to abort REQ after REQ_TIMEOUT cycles.
module tree_node_writer
  import bster_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int KEY_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int REQ_TIMEOUT = 64,
  localparam int NODE_WIDTH = 1 + KEY_WIDTH + DATA_WIDTH + 2 * RAM_ADDR_WIDTH
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [KEY_WIDTH-1:0]      cmd_key,
  input  logic [DATA_WIDTH-1:0]     cmd_data,
  output logic                      tree_mgt_req_valid,
  input  logic                      tree_mgt_req_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] tree_mgt_req_addr,
  input  logic                      tree_mgt_full,
  output logic                      ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [NODE_WIDTH-1:0]     ram_wr_data,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [RAM_ADDR_WIDTH-1:0] done_addr,
  output logic [1:0]                done_status,
  output logic [RAM_ADDR_WIDTH:0]   node_count
);
  state_e state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic cmd_ready_q, cmd_ready_d;
  logic req_valid_q, req_valid_d;
  logic ram_wr_en_q, ram_wr_en_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [NODE_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
  logic done_valid_q, done_valid_d;
  logic [RAM_ADDR_WIDTH-1:0] done_addr_q, done_addr_d;
  logic [1:0] done_status_q, done_status_d;
  logic [RAM_ADDR_WIDTH:0] node_count_q, node_count_d;
  logic cmd_hs, req_hs, done_hs, tmo_hit;
  assign cmd_hs = cmd_valid && cmd_ready_q;
  assign req_hs = req_valid_q && tree_mgt_req_ready;
  assign done_hs = done_valid_q && done_ready;
`ifdef TREE_WRITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(REQ_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  // Zero outside REQ, so it starts from 0 on every entry into REQ.
  assign tmo_d = (state_q == S_REQ) ? tmo_q + TMO_W'(1) : '0;
  assign tmo_hit = tmo_q == TMO_W'(REQ_TIMEOUT - 1);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  localparam int unused_req_timeout = REQ_TIMEOUT;
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    key_d = cmd_hs ? cmd_key : key_q;
    data_d = cmd_hs ? cmd_data : data_q;
    ram_addr_d = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    done_addr_d = done_addr_q;
    done_status_d = done_status_q;
    node_count_d = node_count_q;
    case (state_q)
      S_IDLE: state_d = cmd_hs ? S_REQ : S_IDLE;
      S_REQ: begin
        // A grant wins over a simultaneous full indication.
        if (req_hs) begin
          state_d = S_WRITE;
          ram_addr_d = tree_mgt_req_addr;
          ram_wr_data_d = NODE_WIDTH'(pack_node(NODE_MAX'(key_q), NODE_MAX'(data_q),
                                                RAM_ADDR_WIDTH, KEY_WIDTH, DATA_WIDTH));
        end else if (tree_mgt_full || tmo_hit) begin
          state_d = S_RESP;
          done_addr_d = '0;
          done_status_d = tree_mgt_full ? ST_FULL : ST_TIMEOUT;
        end
      end
      S_WRITE: begin
        state_d = S_RESP;
        done_addr_d = ram_addr_q;
        done_status_d = ST_OK;
        node_count_d = &node_count_q ? node_count_q : node_count_q + 1'b1;
      end
      S_RESP: state_d = done_hs ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered copies of the next state.
    cmd_ready_d = state_d == S_IDLE;
    req_valid_d = state_d == S_REQ;
    ram_wr_en_d = state_d == S_WRITE;
    done_valid_d = state_d == S_RESP;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      key_q <= '0;
      data_q <= '0;
      cmd_ready_q <= 1'b0;
      req_valid_q <= 1'b0;
      ram_wr_en_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wr_data_q <= '0;
      done_valid_q <= 1'b0;
      done_addr_q <= '0;
      done_status_q <= ST_OK;
      node_count_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      data_q <= data_d;
      cmd_ready_q <= cmd_ready_d;
      req_valid_q <= req_valid_d;
      ram_wr_en_q <= ram_wr_en_d;
      ram_addr_q <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      done_valid_q <= done_valid_d;
      done_addr_q <= done_addr_d;
      done_status_q <= done_status_d;
      node_count_q <= node_count_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign tree_mgt_req_valid = req_valid_q;
  assign ram_wr_en = ram_wr_en_q;
  assign ram_addr = ram_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign done_valid = done_valid_q;
  assign done_addr = done_addr_q;
  assign done_status = done_status_q;
  assign node_count = node_count_q;
endmodule

// File: tb/tb_tree_node_writer.sv
// tb_tree_node_writer: scoreboard bench for tree_node_writer.
module tb_tree_node_writer;
  localparam int AW = 16;
  localparam int KW = 8;
  localparam int DW = 8;
  localparam int NW = 1 + KW + DW + 2 * AW;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [KW-1:0] cmd_key = '0;
  logic [DW-1:0] cmd_data = '0;
  logic tree_mgt_req_valid, tree_mgt_req_ready = 1'b0, tree_mgt_full = 1'b0;
  logic [AW-1:0] tree_mgt_req_addr = '0;
  logic ram_wr_en, done_valid, done_ready = 1'b1;
  logic [AW-1:0] ram_addr, done_addr;
  logic [NW-1:0] ram_wr_data;
  logic [1:0] done_status;
  logic [AW:0] node_count;
  always #5 aclk = ~aclk;
  tree_node_writer #(.RAM_ADDR_WIDTH(AW), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .REQ_TIMEOUT(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_data(cmd_data),
    .tree_mgt_req_valid(tree_mgt_req_valid), .tree_mgt_req_ready(tree_mgt_req_ready),
    .tree_mgt_req_addr(tree_mgt_req_addr), .tree_mgt_full(tree_mgt_full),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_addr(done_addr),
    .done_status(done_status), .node_count(node_count)
  );
  typedef struct packed {logic [AW-1:0] addr; logic [NW-1:0] data;} wr_t;
  typedef struct packed {logic [AW-1:0] addr; logic [1:0] st; logic [AW:0] cnt;} dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  int total = 0, bad = 0, writes = 0, w0 = 0, n = 0;
  logic [AW:0] exp_count = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic exp_ok(input logic [AW-1:0] a, input logic [KW-1:0] k, input logic [DW-1:0] d);
    wr_q.push_back({a, 1'b1, k, d, {AW{1'b1}}, {AW{1'b1}}});
    exp_count++;
    dn_q.push_back({a, 2'b00, exp_count});
  endtask
  task automatic exp_err(input logic [1:0] st);
    dn_q.push_back({{AW{1'b0}}, st, exp_count});
  endtask
  // Monitor runs just after the falling edge so it sees inputs driven there.
  always @(negedge aclk) begin
    wr_t we;
    dn_t de;
    #1;
    if (aresetn) begin
      if (ram_wr_en) begin
        writes++;
        if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
        else begin
          we = wr_q.pop_front();
          chk("wr_addr", 64'(ram_addr), 64'(we.addr));
          chk("wr_data", 64'(ram_wr_data), 64'(we.data));
        end
      end
      if (done_valid && done_ready) begin
        if (dn_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else begin
          de = dn_q.pop_front();
          chk("done_addr", 64'(done_addr), 64'(de.addr));
          chk("done_status", 64'(done_status), 64'(de.st));
          chk("node_count", 64'(node_count), 64'(de.cnt));
        end
      end
    end
  end
  task automatic send(input logic [KW-1:0] k, input logic [DW-1:0] d);
    cmd_key = k;
    cmd_data = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge aclk);
    if (!cmd_ready) chk("cmd_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 100 && !done_valid; i++) @(negedge aclk);
    if (!done_valid) chk("done_timeout", 64'd0, 64'd1);
    @(negedge aclk);
  endtask
  initial begin
    repeat (2) @(negedge aclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_req_valid", 64'(tree_mgt_req_valid), 64'd0);
    chk("rst_wr_en", 64'(ram_wr_en), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_node_count", 64'(node_count), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    // Basic insert with latency checks.
    tree_mgt_req_ready = 1'b1;
    tree_mgt_req_addr = 16'h0003;
    exp_ok(16'h0003, 8'h2A, 8'h55);
    send(8'h2A, 8'h55);
    @(negedge aclk);
    chk("lat_req_valid", 64'(tree_mgt_req_valid), 64'd1);
    chk("lat_no_early_wr", 64'(ram_wr_en), 64'd0);
    @(negedge aclk);
    chk("lat_wr_en", 64'(ram_wr_en), 64'd1);
    @(negedge aclk);
    chk("lat_done_valid", 64'(done_valid), 64'd1);
    chk("lat_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    chk("lat_cmd_ready_back", 64'(cmd_ready), 64'd1);
    // Grant delayed five cycles.
    tree_mgt_req_ready = 1'b0;
    tree_mgt_req_addr = 16'h1234;
    exp_ok(16'h1234, 8'h11, 8'h22);
    w0 = writes;
    send(8'h11, 8'h22);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (!tree_mgt_req_valid) break;
      n++;
      if (i >= 5) tree_mgt_req_ready = 1'b1;
    end
    chk("delay_req_cycles", 64'(n), 64'd6);
    wait_done();
    chk("delay_one_write", 64'(writes - w0), 64'd1);
    // Full without grant.
    tree_mgt_req_ready = 1'b0;
    tree_mgt_full = 1'b1;
    exp_err(2'b01);
    w0 = writes;
    send(8'h33, 8'h44);
    wait_done();
    chk("full_no_write", 64'(writes - w0), 64'd0);
    // Grant and full together, to root address 0.
    tree_mgt_req_ready = 1'b1;
    tree_mgt_req_addr = 16'h0000;
    exp_ok(16'h0000, 8'h66, 8'h77);
    w0 = writes;
    send(8'h66, 8'h77);
    wait_done();
    chk("grant_wins_write", 64'(writes - w0), 64'd1);
    tree_mgt_full = 1'b0;
    // Done backpressure with a second command waiting.
    done_ready = 1'b0;
    tree_mgt_req_addr = 16'h00A0;
    exp_ok(16'h00A0, 8'h81, 8'h91);
    exp_ok(16'h00A0, 8'h82, 8'h92);
    send(8'h81, 8'h91);
    cmd_key = 8'h82;
    cmd_data = 8'h92;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !done_valid; i++) @(negedge aclk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_done_valid", 64'(done_valid), 64'd1);
      chk("bp_done_addr", 64'(done_addr), 64'h00A0);
      @(negedge aclk);
    end
    done_ready = 1'b1;
    @(negedge aclk);
    chk("bp_release_ready", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
    @(negedge aclk);
    chk("bp_second_req", 64'(tree_mgt_req_valid), 64'd1);
    wait_done();
    // Reset while in REQ.
    tree_mgt_req_ready = 1'b0;
    send(8'hC1, 8'hC2);
    @(negedge aclk);
    chk("mid_in_req", 64'(tree_mgt_req_valid), 64'd1);
    w0 = writes;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_req_valid", 64'(tree_mgt_req_valid), 64'd0);
    chk("mid_rst_outputs", 64'({cmd_ready, ram_wr_en, done_valid, done_status}), 64'd0);
    chk("mid_rst_count", 64'(node_count), 64'd0);
    exp_count = '0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    tree_mgt_req_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("mid_rst_no_write", 64'(writes - w0), 64'd0);
    chk("mid_rst_idle", 64'(cmd_ready), 64'd1);
    tree_mgt_req_addr = 16'h55AA;
    exp_ok(16'h55AA, 8'hE1, 8'hE2);
    send(8'hE1, 8'hE2);
    wait_done();
`ifdef TREE_WRITER_TIMEOUT_EN
    tree_mgt_req_ready = 1'b0;
    exp_err(2'b10);
    send(8'hF1, 8'hF2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (!tree_mgt_req_valid) break;
      n++;
    end
    chk("tmo_req_cycles", 64'(n), 64'd4);
    wait_done();
`endif
    repeat (2) @(negedge aclk);
    chk("wr_left", 64'(wr_q.size()), 64'd0);
    chk("done_left", 64'(dn_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
